// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control encodings and multiply-sequencer state encoding.
// Control words are packed in zx nx zy ny f no order.
package alu_ctrl_pkg;

  localparam logic [5:0] ALU_ADD    = 6'b000010;
  localparam logic [5:0] ALU_PASS_X = 6'b001100;
  localparam logic [5:0] ALU_AND    = 6'b000000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DBL  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add 16x16->16 multiplier that borrows the external Hack ALU for every add and doubling.
// Optional early exit on an exhausted multiplier: define ALU_MUL_EARLY_EXIT_EN.
import alu_ctrl_pkg::*;

module alu_mul_sequencer #(
  parameter int N_ITER = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        res_zr,
  output logic        res_ng,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic        alu_zx,
  output logic        alu_nx,
  output logic        alu_zy,
  output logic        alu_ny,
  output logic        alu_f,
  output logic        alu_no,
  input  logic [15:0] alu_out,
  input  logic        alu_zr,
  input  logic        alu_ng
);

  localparam logic [4:0] LAST_CNT = 5'(N_ITER - 1);

  state_t      state, state_nx;
  logic [15:0] p_q, m_q, b_q;
  logic [4:0]  cnt_q;
  logic        zr_tmp, ng_tmp;
  logic [15:0] result_q;
  logic        res_zr_q, res_ng_q;
  logic [5:0]  ctrl;
  logic [15:0] b_next;

  assign b_next = b_q >> 1;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = STEP;
      STEP: state_nx = DBL;
      DBL: begin
        if (cnt_q == LAST_CNT) state_nx = DONE;
        else                   state_nx = STEP;
`ifdef ALU_MUL_EARLY_EXIT_EN
        if (b_next == 16'h0000) state_nx = DONE;
`endif
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    alu_x = '0;
    alu_y = '0;
    ctrl  = ALU_AND;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      STEP: begin
        alu_x = p_q;
        alu_y = m_q;
        ctrl  = b_q[0] ? ALU_ADD : ALU_PASS_X;
        busy  = 1'b1;
      end
      DBL: begin
        alu_x = m_q;
        alu_y = m_q;
        ctrl  = ALU_ADD;
        busy  = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ctrl;

  // Outputs show the fresh product during the done cycle, then the held copy.
  assign result = (state == DONE) ? p_q    : result_q;
  assign res_zr = (state == DONE) ? zr_tmp : res_zr_q;
  assign res_ng = (state == DONE) ? ng_tmp : res_ng_q;

  // NOTE: all datapath registers are plain flops with a reset value; a reset
  // mid-operation therefore discards the in-flight product entirely.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_q      <= '0;
      m_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      zr_tmp   <= 1'b0;
      ng_tmp   <= 1'b0;
      result_q <= '0;
      res_zr_q <= 1'b1;
      res_ng_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          p_q   <= '0;
          m_q   <= a;
          b_q   <= b;
          cnt_q <= '0;
        end
        STEP: begin
          p_q    <= alu_out;
          zr_tmp <= alu_zr;
          ng_tmp <= alu_ng;
        end
        DBL: begin
          m_q   <= alu_out;
          b_q   <= b_next;
          cnt_q <= cnt_q + 5'd1;
        end
        DONE: begin
          result_q <= p_q;
          res_zr_q <= zr_tmp;
          res_ng_q <= ng_tmp;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
- Multi-cycle controller that computes a 16x16 to 16-bit multiply (low half; identical for signed and unsigned) by sequencing the Hack ALU.
- Uses a shift-and-add algorithm. The ALU performs every addition and every doubling; this block only holds operands, drives the ALU control bits and captures results.
- Sits beside the CPU datapath. The ALU is external: this block drives its x/y/control inputs and reads out/zr/ng.
- Start/busy/done handshake toward the requester.

Parameters:
- N_ITER, 16, number of multiplier bits processed, LSB first. Legal range 1..16. Higher multiplier bits are ignored.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- a  in  16  multiplicand, latched when start is accepted
- b  in  16  multiplier, latched when start is accepted
- busy  out  1  high while an operation is in progress, i.e. in STEP, DBL or DONE
- done  out  1  one-cycle pulse; result/zr/ng valid from this cycle
- result  out  16  product low 16 bits; held until the next DONE
- res_zr  out  1  result == 0
- res_ng  out  1  result[15]
- alu_x, alu_y  out  16  ALU operands
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  out  1 each  ALU control bits
- alu_out  in  16  ALU result
- alu_zr, alu_ng  in  1  ALU flags

Behaviour:
- Clock and reset: single clock `clk`. Reset is synchronous and active-high on `reset`.
- Reset values: state=IDLE; busy=0; done=0; result=0; res_zr=1; res_ng=0; internal P, M, B and cnt all 0.
- Internal registers: P (product), M (multiplicand), B (multiplier shift register), cnt (iteration counter).
- IDLE, start=1: P<=0, M<=a, B<=b, cnt<=0, go to STEP. If start=0, stay in IDLE.
- STEP:
  - Drive alu_x=P, alu_y=M.
  - If B[0]=1, control = ADD (zx nx zy ny f no = 000010). Otherwise control = PASS_X (001100), which gives x & 0xFFFF.
  - P<=alu_out; latch zr_tmp<=alu_zr and ng_tmp<=alu_ng. Go to DBL.
- DBL:
  - Drive alu_x=alu_y=M, control = ADD.
  - M<=alu_out; B<=B>>1 with 0 shifted in; cnt<=cnt+1.
  - If cnt==N_ITER-1, go to DONE; otherwise go to STEP.
- DONE:
  - done=1; result<=P, res_zr<=zr_tmp, res_ng<=ng_tmp. These registers update on the edge leaving DONE; result/res_zr/res_ng are also driven combinationally from P/zr_tmp/ng_tmp during DONE, so they are valid in the done cycle.
  - Go to IDLE unconditionally.
- ALU outputs in IDLE/DONE: alu_x=alu_y=0, all control bits 0 (x&y).
- ALU outputs are purely combinational from state and registers. The ALU is combinational, so each STEP/DBL takes exactly one cycle.
- Latency (feature off): with start sampled at edge E0, done is high in the cycle after edge E(2*N_ITER). For N_ITER=16 that is 33 cycles after acceptance.
- Throughput: next start is accepted at the earliest one cycle after done. There is no back-to-back acceptance in DONE.
- Start while busy (STEP/DBL/DONE): ignored, not queued.
- Overflow: bits above 15 are silently discarded. M doubling wraps mod 2^16.
- Reset mid-operation: immediate return to IDLE. result/res_* return to reset values, and the in-flight operation is lost.

Optional Feature:
- Macro: ALU_MUL_EARLY_EXIT_EN.
- Defined: in DBL, if the next B (B>>1) is 0, go to DONE regardless of cnt. Latency becomes 2*(index of highest set bit of b within N_ITER, plus 1) + 1 cycles; b=0 gives 3 cycles.
- Undefined: fixed latency as above.
- Results are identical either way.

Decomposition:
- Package alu_ctrl_pkg holds:
  - 6-bit ALU control constants: ALU_ADD=6'b000010, ALU_PASS_X=6'b001100, ALU_AND=6'b000000, packed in zx..no order.
  - State encoding: IDLE, STEP, DBL, DONE as 2-bit constants.
- No sub-module. The shift register and counter are inline. The ALU is instantiated by the parent, or by the bench.

Test Plan:
- a=3, b=5, N_ITER=16, feature off -> done in the cycle after E32; result=15, res_zr=0, res_ng=0; busy high for 33 cycles.
- a=0xFFFF, b=0xFFFF -> result=0x0001, res_ng=0. Then a=0xFFFD (-3), b=7 -> result=0xFFEB (-21), res_ng=1.
- a=0x0100, b=0x0100 -> result=0x0000 (overflow wrap), res_zr=1.
- Start re-asserted with a=9, b=9 during STEP/DBL/DONE of a 3*5 op -> ignored; result=15. A new start one cycle after done -> 81.
- reset pulsed mid-op (cycle 10 after start) -> next cycle IDLE, busy=0, done never pulses, result=0, res_zr=1. A subsequent 2*2 -> 4.
- With ALU_MUL_EARLY_EXIT_EN: b=5 -> done in the cycle after E6, result=a*5. b=0 -> done in the cycle after E2, result=0, res_zr=1.
